// File: rtl/alu_pkg.sv
// alu_pkg - shared definitions for the registered sequential ALU.
//   Opcode map (4-bit ALU control field), FSM state encoding and the
//   helper that tells which opcodes take the iterative multi-cycle path.
// Ports: none (package).
package alu_pkg;

  // 4-bit opcode map; the original single-cycle codes keep their values
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_MUL  = 4'd3;
  localparam logic [3:0] ALU_DIVU = 4'd4;
  localparam logic [3:0] ALU_REMU = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_NOR  = 4'd12;

  // Control FSM: IDLE accepts, BUSY iterates, DONE holds the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // True for opcodes that run through the iterative mul/div unit
  function automatic logic is_multicycle(input logic [3:0] op);
    logic w_mc;
    case (op)
      ALU_MUL, ALU_DIVU, ALU_REMU: w_mc = 1'b1;
      default:                     w_mc = 1'b0;
    endcase
    return w_mc;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if - operand/result handshake bundle of the sequential ALU.
//   Request side : in_valid_i, in_ready_o, ctrl_i, src1_i, src2_i
//   Response side: out_valid_o, out_ready_i, result_o, zero_o, ovf_o
//   Modport slave is taken by the ALU, master by whoever issues operations.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             ovf_o;

  modport slave (
    input  in_valid_i, ctrl_i, src1_i, src2_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, zero_o, ovf_o
  );

  modport master (
    output in_valid_i, ctrl_i, src1_i, src2_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, zero_o, ovf_o
  );
endinterface

// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit - iterative shift-add multiplier and restoring divider.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   start_i, op_i     : load operands a_i/b_i for the opcode op_i
//   a_i, b_i          : multiplicand/dividend, multiplier/divisor
//   done_o            : high in the cycle whose closing edge performs the
//                       last step; product_o/quotient_o/remainder_o then
//                       carry the final values (combinational next-step)
// One step per cycle, WIDTH steps per operation, no early exit.
module seq_muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;

  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_sub;
  logic             w_fits;

  // Multiply step: add the shifted multiplicand when the multiplier LSB is set
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});

  // Divide step: bring in the next dividend bit (r_quo MSB) and trial-subtract.
  // The partial remainder stays below the divisor, so the borrow bit of the
  // WIDTH+1 wide difference is a reliable "does not fit" flag.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_sub   = w_shift - {1'b0, r_div};
  assign w_fits  = ~w_sub[WIDTH];

  // Restore the shifted remainder when the trial subtraction borrowed
  always_comb begin
    if (w_fits) begin
      w_rem_nxt = w_sub[WIDTH-1:0];
    end else begin
      w_rem_nxt = w_shift[WIDTH-1:0];
    end
  end

  // Dividend bits leave at the top while quotient bits enter at the bottom
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};

  assign done_o      = (r_cnt == CNT_W'(1));
  assign product_o   = w_acc_nxt;
  assign quotient_o  = w_quo_nxt;
  assign remainder_o = w_rem_nxt;

  // Operand load on start, then one iteration per cycle while the counter runs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_acc    <= {WIDTH{1'b0}};
      r_mcand  <= {WIDTH{1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_rem    <= {WIDTH{1'b0}};
      r_quo    <= {WIDTH{1'b0}};
      r_div    <= {WIDTH{1'b0}};
    end else if (start_i) begin
      r_cnt <= CNT_W'(WIDTH);
      if (op_i == ALU_MUL) begin
        r_acc    <= {WIDTH{1'b0}};
        r_mcand  <= a_i;
        r_mplier <= b_i;
      end else begin
        r_rem <= {WIDTH{1'b0}};
        r_quo <= a_i;
        r_div <= b_i;
      end
    end else if (r_cnt != {CNT_W{1'b0}}) begin
      r_cnt    <= r_cnt - CNT_W'(1);
      r_acc    <= w_acc_nxt;
      r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu - registered ALU with valid/ready handshake.
//   clk_i : clock, all state on its rising edge
//   rst_i : synchronous active-high reset
//   bus   : seq_alu_if.slave
//           in_valid_i/in_ready_o + ctrl_i/src1_i/src2_i  (request)
//           out_valid_o/out_ready_i + result_o/zero_o/ovf_o (response)
// AND/OR/ADD/SUB/SLT/SLTU/NOR (and unknown codes) finish on the accept edge;
// MUL/DIVU/REMU run WIDTH cycles in seq_muldiv_unit. The result is held
// in DONE until the consumer takes it; only IDLE accepts new work.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk_i,
  input  logic     rst_i,
  seq_alu_if.slave bus
);

  alu_state_e       r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_out_valid;
  logic             r_in_ready;

  logic             w_accept;
  logic             w_start;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_sc_result;
  logic             w_sc_ovf;
  logic             w_md_done;
  logic [WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_md_result;

  // r_in_ready mirrors "state == IDLE", so this is the handshake
  assign w_accept = bus.in_valid_i & r_in_ready;
  assign w_start  = w_accept & is_multicycle(bus.ctrl_i);

  assign w_sum  = bus.src1_i + bus.src2_i;
  assign w_diff = bus.src1_i - bus.src2_i;

  // Single-cycle result and overflow, evaluated on the live request operands
  always_comb begin
    w_sc_result = {WIDTH{1'b0}};
    w_sc_ovf    = 1'b0;
    case (bus.ctrl_i)
      ALU_AND: w_sc_result = bus.src1_i & bus.src2_i;
      ALU_OR:  w_sc_result = bus.src1_i | bus.src2_i;
      ALU_ADD: begin
        w_sc_result = w_sum;
        // same-sign operands overflow when the result sign flips
        w_sc_ovf = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != bus.src1_i[WIDTH-1]);
      end
      ALU_SUB: begin
        w_sc_result = w_diff;
        // opposite-sign operands overflow when the result leaves A's sign
        w_sc_ovf = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) &&
                   (w_diff[WIDTH-1] != bus.src1_i[WIDTH-1]);
      end
      ALU_SLT:  w_sc_result = {{(WIDTH-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
      ALU_SLTU: w_sc_result = {{(WIDTH-1){1'b0}}, (bus.src1_i < bus.src2_i)};
      ALU_NOR:  w_sc_result = ~(bus.src1_i | bus.src2_i);
      default: begin
        w_sc_result = {WIDTH{1'b0}};
        w_sc_ovf    = 1'b0;
      end
    endcase
  end

  seq_muldiv_unit #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (w_start),
    .op_i        (bus.ctrl_i),
    .a_i         (bus.src1_i),
    .b_i         (bus.src2_i),
    .done_o      (w_md_done),
    .product_o   (w_prod),
    .quotient_o  (w_quo),
    .remainder_o (w_rem)
  );

  // Pick the iterative result that matches the latched opcode
  always_comb begin
    w_md_result = {WIDTH{1'b0}};
    case (r_op)
      ALU_MUL:  w_md_result = w_prod;
      ALU_DIVU: w_md_result = w_quo;
      ALU_REMU: w_md_result = w_rem;
      default:  w_md_result = {WIDTH{1'b0}};
    endcase
  end

  // Control FSM with all handshake and result outputs registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_op        <= ALU_AND;
      r_result    <= {WIDTH{1'b0}};
      r_zero      <= 1'b1;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (is_multicycle(bus.ctrl_i)) begin
              r_op    <= bus.ctrl_i;
              r_state <= BUSY;
            end else begin
              r_result    <= w_sc_result;
              r_zero      <= (w_sc_result == {WIDTH{1'b0}});
              r_ovf       <= w_sc_ovf;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        BUSY: begin
          if (w_md_done) begin
            r_result    <= w_md_result;
            r_zero      <= (w_md_result == {WIDTH{1'b0}});
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready_i) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = r_in_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.result_o    = r_result;
  assign bus.zero_o      = r_zero;
  assign bus.ovf_o       = r_ovf;

endmodule
